// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: shared types and constants for the multi-channel timer bank.
// Rev 1.0
`default_nettype none

package timer_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_MODE   = 1;
   localparam int CTRL_IM     = 3;
   localparam int CTRL_PSC_LO = 8;
   localparam int PSC_W       = 8;

endpackage

`default_nettype wire

// File: rtl/timer_channel.sv
// timer_channel: one down-counter with prescaler, one-shot/auto-reload FSM and W1C pending flag.
// Rev 1.0
`default_nettype none

module timer_channel
   import timer_bank_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ch_sel,
   input  logic             we,
   input  logic [1:0]       reg_sel,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             irq
);

   state_t             state, state_n;
   logic               en, en_n;
   logic               mode, mode_n;
   logic               im, im_n;
   logic [PSC_W-1:0]   psc, psc_n;
   logic [PSC_W-1:0]   psc_cnt, psc_cnt_n;
   logic [CNT_W-1:0]   preset, preset_n;
   logic [CNT_W-1:0]   count, count_n;
   logic               pending, pending_n;
   logic               expire;
   logic               tick;
   logic               wr_ctrl, wr_preset, wr_status;

   assign wr_ctrl   = we && ch_sel && (reg_sel == REG_CTRL);
   assign wr_preset = we && ch_sel && (reg_sel == REG_PRESET);
   assign wr_status = we && ch_sel && (reg_sel == REG_STATUS);
   assign tick      = (psc_cnt == psc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         en      <= 1'b0;
         mode    <= 1'b0;
         im      <= 1'b0;
         psc     <= '0;
         psc_cnt <= '0;
         preset  <= '0;
         count   <= '0;
         pending <= 1'b0;
      end else begin
         state   <= state_n;
         en      <= en_n;
         mode    <= mode_n;
         im      <= im_n;
         psc     <= psc_n;
         psc_cnt <= psc_cnt_n;
         preset  <= preset_n;
         count   <= count_n;
         pending <= pending_n;
      end
   end

   always_comb begin
      state_n   = state;
      count_n   = count;
      psc_cnt_n = psc_cnt;
      expire    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            count_n   = preset;
            psc_cnt_n = '0;
            if (preset == '0) expire = 1'b1;
            else              state_n = ST_CNT;
         end
         ST_CNT: begin
            if (tick) begin
               psc_cnt_n = '0;
               // count <= 1 expires, so the counter can never wrap below zero
               if (count > CNT_W'(1)) begin
                  count_n = count - CNT_W'(1);
               end else begin
                  count_n = '0;
                  expire  = 1'b1;
               end
            end else begin
               psc_cnt_n = psc_cnt + PSC_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (expire) state_n = mode ? ST_LOAD : ST_IDLE;

      // A disabling CTRL write overrides the FSM and freezes COUNT on this edge
      if (wr_ctrl && !wdata[CTRL_EN]) begin
         state_n   = ST_IDLE;
         count_n   = count;
         psc_cnt_n = psc_cnt;
      end

      en_n     = en;
      mode_n   = mode;
      im_n     = im;
      psc_n    = psc;
      preset_n = preset;
      if (expire && !mode) en_n = 1'b0;
      if (wr_ctrl) begin
         en_n   = wdata[CTRL_EN];
         mode_n = wdata[CTRL_MODE];
         im_n   = wdata[CTRL_IM];
         psc_n  = wdata[CTRL_PSC_LO +: PSC_W];
      end
      if (wr_preset) preset_n = wdata[CNT_W-1:0];

      pending_n = pending;
      if (wr_status && wdata[0]) pending_n = 1'b0;
      if (expire)                pending_n = 1'b1;
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_CTRL:   rdata = {16'h0000, psc, 4'h0, im, 1'b0, mode, en};
         REG_PRESET: rdata = 32'(preset);
         REG_COUNT:  rdata = 32'(count);
         default:    rdata = {31'd0, pending};
      endcase
   end

   assign irq = pending && im;

endmodule

`default_nettype wire

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH memory-mapped timer channels with channel decode, read mux and irq reduction.
// Rev 1.0
`default_nettype none

module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk_in,
   input  logic              sys_rstn,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [NUM_CH-1:0] irq,
   output logic              irq_any
);

   localparam int CH_W = ADDR_W - 4;

   logic [CH_W-1:0]   ch_idx;
   logic [1:0]        reg_sel;
   logic [NUM_CH-1:0] ch_sel;
   logic [31:0]       ch_rdata [NUM_CH];
   logic              unused_addr;

   assign ch_idx      = addr[ADDR_W-1:4];
   assign reg_sel     = addr[3:2];
   assign unused_addr = ^addr[1:0];

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         assign ch_sel[i] = (ch_idx == CH_W'(i));

         timer_channel #(
            .CNT_W (CNT_W)
         ) u_ch (
            .clk     (clk_in),
            .rst_n   (sys_rstn),
            .ch_sel  (ch_sel[i]),
            .we      (we),
            .reg_sel (reg_sel),
            .wdata   (wdata),
            .rdata   (ch_rdata[i]),
            .irq     (irq[i])
         );
      end
   endgenerate

   // Out-of-range channel indices match no ch_sel bit and read as zero
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel[i]) rdata = ch_rdata[i];
      end
   end

   assign irq_any = |irq;

endmodule

`default_nettype wire

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scenarios plus randomized runs checked against an arithmetic timing model.
`default_nettype none

module tb_timer_bank;

   logic        clk_in = 1'b0;
   logic        sys_rstn = 1'b0;
   logic [7:0]  addr = '0;
   logic        we = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [1:0]  irq;
   logic        irq_any;

   int n_cmp = 0;
   int n_bad = 0;

   timer_bank #(.NUM_CH(2), .CNT_W(32), .ADDR_W(8)) dut (
      .clk_in   (clk_in),
      .sys_rstn (sys_rstn),
      .addr     (addr),
      .we       (we),
      .wdata    (wdata),
      .rdata    (rdata),
      .irq      (irq),
      .irq_any  (irq_any)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] ra(input int ch, input int r);
      return 8'(ch * 16 + r * 4);
   endfunction

   // All helpers start and end 1 time unit after a rising edge
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk_in);
      #1;
      we    = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      sys_rstn = 1'b0;
      #12;
      sys_rstn = 1'b1;
      tick();
      for (int ch = 0; ch < 2; ch++) begin
         for (int r = 0; r < 4; r++) begin
            rd(ra(ch, r), v);
            n_cmp++;
            if (v !== 32'd0) begin
               n_bad++;
               $display("FAIL reset_reg ch%0d r%0d got %h exp 0", ch, r, v);
            end
         end
         tick();
      end
      n_cmp++;
      if (irq !== 2'b00 || irq_any !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_irq got %b/%b exp 00/0", irq, irq_any);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      wr(ra(0, 1), 32'd5);
      wr(ra(0, 3), 32'd1);
      wr(ra(0, 0), 32'h0000_0009);      // edge 0
      tick();                           // edge 1
      for (int k = 2; k <= 7; k++) begin
         tick();
         rd(ra(0, 2), v);
         n_cmp++;
         if (v !== 32'(5 - (k - 2))) begin
            n_bad++;
            $display("FAIL oneshot_count edge%0d got %0d exp %0d", k, v, 5 - (k - 2));
         end
         n_cmp++;
         if (irq[0] !== (k == 7)) begin
            n_bad++;
            $display("FAIL oneshot_irq edge%0d got %b exp %b", k, irq[0], (k == 7));
         end
      end
      rd(ra(0, 0), v);
      n_cmp++;
      if (v !== 32'h0000_0008) begin
         n_bad++;
         $display("FAIL oneshot_ctrl got %h exp 00000008", v);
      end
      wr(ra(0, 3), 32'd1);
      n_cmp++;
      if (irq[0] !== 1'b0 || irq_any !== 1'b0) begin
         n_bad++;
         $display("FAIL oneshot_clear got %b/%b exp 0/0", irq[0], irq_any);
      end
   endtask

   task automatic test_autoreload();
      logic [31:0] v;
      wr(ra(1, 1), 32'd3);
      wr(ra(1, 0), 32'h0000_0103);      // edge 0: EN, MODE=1, PSC=1, IM=0
      for (int k = 1; k <= 8; k++) begin
         tick();
         rd(ra(1, 3), v);
         n_cmp++;
         if (v !== 32'(k == 8)) begin
            n_bad++;
            $display("FAIL auto_pend1 edge%0d got %0d exp %0d", k, v, (k == 8));
         end
      end
      n_cmp++;
      if (irq[1] !== 1'b0 || irq_any !== 1'b0) begin
         n_bad++;
         $display("FAIL auto_masked got %b/%b exp 0/0", irq[1], irq_any);
      end
      wr(ra(1, 3), 32'd1);              // edge 9 (LOAD)
      rd(ra(1, 2), v);
      n_cmp++;
      if (v !== 32'd3) begin
         n_bad++;
         $display("FAIL auto_reload1 got %0d exp 3", v);
      end
      for (int k = 10; k <= 15; k++) begin
         tick();
         rd(ra(1, 3), v);
         n_cmp++;
         if (v !== 32'(k == 15)) begin
            n_bad++;
            $display("FAIL auto_pend2 edge%0d got %0d exp %0d", k, v, (k == 15));
         end
      end
      tick();
      rd(ra(1, 2), v);
      n_cmp++;
      if (v !== 32'd3) begin
         n_bad++;
         $display("FAIL auto_reload2 got %0d exp 3", v);
      end
      wr(ra(1, 0), 32'd0);
      wr(ra(1, 3), 32'd1);
   endtask

   task automatic test_collision_clear();
      logic [31:0] v;
      wr(ra(0, 1), 32'd2);
      wr(ra(0, 0), 32'h0000_0001);      // edge 0; expiry at edge 4
      tick();
      tick();
      tick();
      wr(ra(0, 3), 32'd1);              // edge 4
      rd(ra(0, 3), v);
      n_cmp++;
      if (v !== 32'd1) begin
         n_bad++;
         $display("FAIL clear_vs_expiry got %0d exp 1", v);
      end
      wr(ra(0, 3), 32'd1);
   endtask

   task automatic test_disable_freeze();
      logic [31:0] v;
      wr(ra(0, 1), 32'd10);
      wr(ra(0, 0), 32'h0000_0001);      // edge 0
      for (int k = 1; k <= 8; k++) tick();
      wr(ra(0, 0), 32'd0);              // edge 9
      rd(ra(0, 2), v);
      n_cmp++;
      if (v !== 32'd4) begin
         n_bad++;
         $display("FAIL freeze_now got %0d exp 4", v);
      end
      for (int k = 0; k < 5; k++) tick();
      rd(ra(0, 2), v);
      n_cmp++;
      if (v !== 32'd4) begin
         n_bad++;
         $display("FAIL freeze_hold got %0d exp 4", v);
      end
      rd(ra(0, 3), v);
      n_cmp++;
      if (v !== 32'd0) begin
         n_bad++;
         $display("FAIL freeze_pend got %0d exp 0", v);
      end
      wr(ra(0, 0), 32'h0000_0001);      // restart: IDLE -> LOAD -> CNT
      tick();
      rd(ra(0, 2), v);
      n_cmp++;
      if (v !== 32'd4) begin
         n_bad++;
         $display("FAIL restart_e1 got %0d exp 4", v);
      end
      tick();
      rd(ra(0, 2), v);
      n_cmp++;
      if (v !== 32'd10) begin
         n_bad++;
         $display("FAIL restart_e2 got %0d exp 10", v);
      end
      wr(ra(0, 0), 32'd0);
   endtask

   task automatic test_edges();
      logic [31:0] v;
      wr(ra(0, 1), 32'd0);
      wr(ra(0, 0), 32'h0000_0009);      // edge 0
      tick();
      rd(ra(0, 3), v);
      n_cmp++;
      if (v !== 32'd0) begin
         n_bad++;
         $display("FAIL zero_preset_e1 got %0d exp 0", v);
      end
      tick();
      rd(ra(0, 3), v);
      n_cmp++;
      if (v !== 32'd1 || irq[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL zero_preset_e2 got %0d/%b exp 1/1", v, irq[0]);
      end
      rd(ra(0, 0), v);
      n_cmp++;
      if (v !== 32'h0000_0008) begin
         n_bad++;
         $display("FAIL zero_preset_ctrl got %h exp 00000008", v);
      end
      wr(ra(0, 3), 32'd1);
      wr(ra(0, 2), 32'h0000_0055);
      rd(ra(0, 2), v);
      n_cmp++;
      if (v !== 32'd0) begin
         n_bad++;
         $display("FAIL count_ro got %h exp 0", v);
      end
      wr(8'h20, 32'hFFFF_FFFF);
      wr(8'h24, 32'h1234_5678);
      wr(8'h2C, 32'h0000_0001);
      for (int r = 0; r < 4; r++) begin
         rd(ra(2, r), v);
         n_cmp++;
         if (v !== 32'd0) begin
            n_bad++;
            $display("FAIL ch2_read r%0d got %h exp 0", r, v);
         end
      end
      tick();
      rd(ra(0, 0), v);
      n_cmp++;
      if (v !== 32'h0000_0008) begin
         n_bad++;
         $display("FAIL ch2_alias_ctrl0 got %h exp 00000008", v);
      end
      rd(ra(1, 1), v);
      n_cmp++;
      if (v !== 32'd3) begin
         n_bad++;
         $display("FAIL ch2_alias_preset1 got %h exp 3", v);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      wr(ra(1, 1), 32'd0);
      wr(ra(1, 0), 32'h0000_0009);
      wr(ra(0, 1), 32'd50);
      wr(ra(0, 0), 32'h0000_0009);
      for (int k = 0; k < 10; k++) tick();
      rd(ra(0, 2), v);
      n_cmp++;
      if (v !== 32'd42 || irq !== 2'b10) begin
         n_bad++;
         $display("FAIL pre_reset got %0d/%b exp 42/10", v, irq);
      end
      tick();
      sys_rstn = 1'b0;
      rd(ra(0, 2), v);
      n_cmp++;
      if (v !== 32'd0) begin
         n_bad++;
         $display("FAIL async_count got %0d exp 0", v);
      end
      rd(ra(1, 3), v);
      n_cmp++;
      if (v !== 32'd0 || irq !== 2'b00 || irq_any !== 1'b0) begin
         n_bad++;
         $display("FAIL async_pend got %0d/%b/%b exp 0/00/0", v, irq, irq_any);
      end
      @(negedge clk_in);
      @(negedge clk_in);
      sys_rstn = 1'b1;
      tick();
   endtask

   // Model: after the enable edge, COUNT = PRESET - floor(t/(PSC+1)) with t the
   // cycles since the first load, folded by the reload period or capped for one-shot.
   task automatic test_random();
      logic [31:0] v;
      for (int it = 0; it < 8; it++) begin
         int ch, pre, psc, mode, im, per, e, t, exp_cnt;
         bit exp_p;
         ch   = int'($urandom_range(0, 1));
         pre  = int'($urandom_range(1, 12));
         psc  = int'($urandom_range(0, 3));
         mode = int'($urandom_range(0, 1));
         im   = int'($urandom_range(0, 1));
         per  = pre * (psc + 1) + 1;
         e    = 2 + pre * (psc + 1);
         wr(ra(ch, 0), 32'd0);
         wr(ra(ch, 3), 32'd1);
         wr(ra(ch, 1), 32'(pre));
         wr(ra(ch, 0), 32'((psc << 8) | (im << 3) | (mode << 1) | 1));
         for (int k = 1; k <= 2 * per + 4; k++) begin
            tick();
            if (k >= 2) begin
               t = (mode != 0) ? (k - 2) % per : ((k - 2 < per - 1) ? k - 2 : per - 1);
               exp_cnt = pre - t / (psc + 1);
               rd(ra(ch, 2), v);
               n_cmp++;
               if (v !== 32'(exp_cnt)) begin
                  n_bad++;
                  $display("FAIL rnd_count it%0d ch%0d k%0d got %0d exp %0d", it, ch, k, v, exp_cnt);
               end
            end
            exp_p = (k >= e);
            rd(ra(ch, 3), v);
            n_cmp++;
            if (v !== 32'(exp_p) || irq[ch] !== (exp_p && im != 0) || irq_any !== (exp_p && im != 0)) begin
               n_bad++;
               $display("FAIL rnd_pend it%0d ch%0d k%0d got %0d/%b/%b exp %0d/%b",
                        it, ch, k, v, irq[ch], irq_any, exp_p, (exp_p && im != 0));
            end
         end
         wr(ra(ch, 0), 32'd0);
         wr(ra(ch, 3), 32'd1);
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_autoreload();
      test_collision_clear();
      test_disable_freeze();
      test_edges();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
